// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - pipeline-to-muldiv handshake and HI/LO result bundle
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic            cpu_stall;
  logic            stall_cc;
  logic            over_cc;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, cpu_stall,
    input  stall_cc, over_cc, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, cpu_stall,
    output stall_cc, over_cc, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic              neg_q;
  logic              neg_r;
  logic              div0_q;
  logic [5:0]        cnt;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              over_q;
  logic              stall_c;

  logic              is_signed;
  logic              neg_in;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic              fast_go;
  logic [2*XLEN-1:0] fast_prod;

  assign is_signed = ~bus.op[0];
  assign neg_in    = is_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
  assign mag_a     = (is_signed & bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign mag_b     = (is_signed & bus.b[XLEN-1]) ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  assign fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_prod = neg_in ? -fast_mag : fast_mag;
  assign fast_go   = ~bus.op[1];
`else
  assign fast_prod = '0;
  assign fast_go   = 1'b0;
`endif

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (op_q[1]) begin
      if (!div_trial[XLEN])
        acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_step = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q ? -acc_step : acc_step;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (op_q[1]) begin
      if (div0_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        res_hi = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      end
    end
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stall_c    = 1'b1;
          state_next = fast_go ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == 6'd31)
          state_next = DONE;
      end
      DONE: begin
        if (!bus.cpu_stall)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      over_q <= 1'b0;
    end else begin
      state  <= state_next;
      over_q <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      opb_q  <= '0;
      a_q    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            opb_q  <= mag_b;
            a_q    <= bus.a;
            acc    <= {{XLEN{1'b0}}, mag_a};
            neg_q  <= neg_in;
            neg_r  <= is_signed & bus.a[XLEN-1];
            div0_q <= (bus.b == '0);
            cnt    <= '0;
            if (fast_go) begin
              hi_q <= fast_prod[2*XLEN-1:XLEN];
              lo_q <= fast_prod[XLEN-1:0];
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.a;
            if (bus.lo_we) lo_q <= bus.a;
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // gated by reset so the controller sees no stall while the unit is held in reset
  assign bus.stall_cc = rst & stall_c;
  assign bus.over_cc  = over_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
